sram_write_ctrl: RTL and testbench

Downstream consumer of the edge-detection output buffer. It requests each packed 32-bit edge word when the buffer reports full, captures word and address into a small write FIFO, and drives the SRAM write port with a valid/ack handshake. At end of image it drains the FIFO, issues the final completion-flag write, and raises `write_done`.

---
 rtl/sobel_pkg.sv | 21 ++
 rtl/sram_write_ctrl_if.sv | 25 ++
 rtl/write_fifo.sv | 63 ++++++
 rtl/sram_write_ctrl.sv | 156 +++++++++++++++
 tb/tb_sram_write_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel edge pipeline's SRAM write path.
package sobel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT_WORD,
    FLUSH,
    FLAG,
    DONE
  } wrReqState;

  localparam logic [31:0] DONE_FLAG_ADDR = 32'd4;
  localparam logic [31:0] DONE_FLAG_WORD = 32'd1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_entry_t;

endpackage

// File: rtl/sram_write_ctrl_if.sv
// SRAM write port bundle: valid/ack request with address and data.
interface sram_write_ctrl_if #(
  parameter int ADDR_W = 32
);

  logic              sram_wr;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic              sram_ack;

  modport master (
    output sram_wr,
    output sram_addr,
    output sram_wdata,
    input  sram_ack
  );

  modport slave (
    input  sram_wr,
    input  sram_addr,
    input  sram_wdata,
    output sram_ack
  );

endinterface

// File: rtl/write_fifo.sv
// Power-of-two circular FIFO holding pending {addr, data} write requests.
module write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/sram_write_ctrl.sv
// Pulls packed edge words from the output buffer, queues them and writes them to SRAM,
// finishing with the completion flag. Optional SRAM_WRITE_COUNT_EN adds write/overflow counters.
module sram_write_ctrl
  import sobel_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     out_full,
  input  logic                     out_empty,
  input  logic [31:0]              out_pixel,
  input  logic [ADDR_W-1:0]        write_addr,
  input  logic                     img_done,
  output logic                     write_out_enable,
  sram_write_ctrl_if.master        sram,
  output logic                     write_done
`ifdef SRAM_WRITE_COUNT_EN
  ,
  output logic [15:0]              words_written,
  output logic                     fifo_overflow_err
`endif
);

  localparam int EW = ADDR_W + 32;

  wrReqState                   state_q, state_d;
  logic                        push, pop;
  logic [EW-1:0]               push_data, head;
  logic                        fifo_empty, fifo_full;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;

  logic                        wr_q, wr_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [31:0]                 data_q, data_d;
  logic                        wr_accepted;

  assign push_data   = {write_addr, out_pixel};
  assign wr_accepted = wr_q && sram.sram_ack;

  write_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    push             = 1'b0;
    write_out_enable = 1'b0;
    write_done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (img_done)                    state_d = FLUSH;
        else if (out_full && !fifo_full) state_d = GRANT;
      end
      GRANT: begin
        write_out_enable = 1'b1;
        state_d          = WAIT_WORD;
      end
      WAIT_WORD: begin
        if (out_empty) begin
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      // Flag goes out only once every image word has been acknowledged.
      FLUSH: begin
        if (fifo_count == '0 && !wr_q) begin
          push    = 1'b1;
          state_d = FLAG;
        end
      end
      FLAG: begin
        if (wr_accepted) state_d = DONE;
      end
      DONE: begin
        write_done = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue stage: a single outstanding write, refilled from the FIFO head once idle.
  assign pop = !wr_q && !fifo_empty;

  always_comb begin
    wr_d   = wr_q;
    addr_d = addr_q;
    data_d = data_q;
    if (pop) begin
      wr_d   = 1'b1;
      addr_d = head[EW-1:32];
      data_d = head[31:0];
    end else if (wr_accepted) begin
      wr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wr_q   <= wr_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign sram.sram_wr    = wr_q;
  assign sram.sram_addr  = addr_q;
  assign sram.sram_wdata = data_q;

`ifdef SRAM_WRITE_COUNT_EN
  logic [15:0] words_q, words_d;
  logic        ovf_q, ovf_d;

  always_comb begin
    words_d = words_q;
    ovf_d   = ovf_q;
    if (wr_accepted && words_q != 16'hFFFF) words_d = words_q + 16'd1;
    if (push && fifo_full)                  ovf_d   = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      words_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      words_q <= words_d;
      ovf_q   <= ovf_d;
    end
  end

  assign words_written     = words_q;
  assign fifo_overflow_err = ovf_q;
`endif

endmodule

// File: tb/tb_sram_write_ctrl.sv
// Randomized scoreboard bench for sram_write_ctrl: buffer responder, SRAM slave with monitor.
module tb_sram_write_ctrl;
  import sobel_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int ADDR_W     = 32;

  logic        clk;
  logic        n_rst;
  logic        out_full, out_empty, img_done;
  logic [31:0] out_pixel;
  logic [31:0] write_addr;
  logic        write_out_enable, write_done;
`ifdef SRAM_WRITE_COUNT_EN
  logic [15:0] words_written;
  logic        fifo_overflow_err;
`endif

  sram_write_ctrl_if #(.ADDR_W(ADDR_W)) sif ();

  sram_write_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk              (clk),
    .n_rst            (n_rst),
    .out_full         (out_full),
    .out_empty        (out_empty),
    .out_pixel        (out_pixel),
    .write_addr       (write_addr),
    .img_done         (img_done),
    .write_out_enable (write_out_enable),
    .sram             (sif),
    .write_done       (write_done)
`ifdef SRAM_WRITE_COUNT_EN
    ,
    .words_written    (words_written),
    .fifo_overflow_err(fifo_overflow_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Words the buffer still has to hand over, and the writes the SRAM must see in order.
  logic [63:0] src_q[$];
  logic [63:0] exp_q[$];
  int          acc_cyc[$];

  int grants = 0, acks = 0;
  int phase = 0;
  int full_rise_cyc = -1, grant_cyc = -1, cap_cyc = -1, rise_cyc = -1, last_acc_cyc = -1;
  bit img_req = 0;
  logic [31:0] flag_addr = '0, flag_data = '0;
  bit ack_block = 0, ack_rand = 0, ack_noise = 0;
  int ack_delay = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_woe"},   {63'd0, write_out_enable}, 64'd0);
    check({tag, "_wr"},    {63'd0, sif.sram_wr},      64'd0);
    check({tag, "_addr"},  {32'd0, sif.sram_addr},    64'd0);
    check({tag, "_wdata"}, {32'd0, sif.sram_wdata},   64'd0);
    check({tag, "_done"},  {63'd0, write_done},       64'd0);
`ifdef SRAM_WRITE_COUNT_EN
    check({tag, "_words"}, {48'd0, words_written},    64'd0);
    check({tag, "_ovf"},   {63'd0, fifo_overflow_err}, 64'd0);
`endif
  endtask

  task automatic wait_acks(input int target, input string nm);
    int b = 0;
    while (acks < target && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check(nm, acks, target);
  endtask

  task automatic wait_idle(input string nm);
    int b = 0;
    while ((src_q.size() != 0 || phase != 0) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check(nm, {63'd0, (src_q.size() == 0 && phase == 0)}, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input string nm, output int dcyc);
    int b = 0;
    while (!write_done && b < 3000) begin
      @(negedge clk);
      b++;
    end
    check(nm, {63'd0, write_done}, 64'd1);
    dcyc = cyc;
  endtask

  // Output-buffer model: answers each grant two cycles later with the next queued word.
  initial begin
    logic [63:0] w;
    bit          nf;
    out_full = 0; out_empty = 0; img_done = 0; out_pixel = '0; write_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      out_empty = 1'b0;
      if (phase == 2) begin
        check("grant_one_cycle", {63'd0, write_out_enable}, 64'd0);
        phase = 1;
      end else if (phase == 1) begin
        w          = src_q.pop_front();
        write_addr = w[63:32];
        out_pixel  = w[31:0];
        out_empty  = 1'b1;
        exp_q.push_back(w);
        cap_cyc    = cyc;
        phase      = 0;
      end else if (write_out_enable) begin
        grants++;
        grant_cyc = cyc;
        check("grant_has_word", {63'd0, (src_q.size() != 0)}, 64'd1);
        if (src_q.size() != 0) phase = 2;
      end
      img_done = img_req;
      if (img_req && phase == 0 && !out_empty) begin
        write_addr = flag_addr;
        out_pixel  = flag_data;
      end
      nf = (src_q.size() != 0) && !(phase == 0 && out_empty && src_q.size() == 0);
      if (nf && !out_full) full_rise_cyc = cyc;
      out_full = nf;
    end
  end

  // SRAM slave and write monitor: every presented write must equal the scoreboard head.
  initial begin
    bit in_wr = 0, just_acked = 0;
    int wcnt = 0, d = 0;
    sif.sram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        in_wr = 0; just_acked = 0; sif.sram_ack = 1'b0;
      end else begin
        if (just_acked) begin
          check("wr_drop_after_ack", {63'd0, sif.sram_wr}, 64'd0);
          just_acked = 0;
        end
        if (sif.sram_wr) begin
          if (!in_wr) begin
            in_wr = 1; wcnt = 0; rise_cyc = cyc;
            d = ack_rand ? int'($urandom_range(0, 3)) : ack_delay;
          end
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got %h/%h, expected none (cycle %0d)",
                     sif.sram_addr, sif.sram_wdata, cyc);
          end else begin
            check("write_addr_data", {sif.sram_addr, sif.sram_wdata}, exp_q[0]);
          end
          if (!ack_block && wcnt >= d) begin
            sif.sram_ack = 1'b1;
            acks++;
            acc_cyc.push_back(cyc);
            last_acc_cyc = cyc;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            in_wr = 0; just_acked = 1;
          end else begin
            sif.sram_ack = 1'b0;
            wcnt++;
          end
        end else begin
          in_wr = 0;
          sif.sram_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0, a0, dcyc;
    logic [63:0] w;
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1 n_rst = 1'b1;

    // Single word with a 3-cycle ack delay
    ack_delay = 3;
    @(negedge clk);
    src_q.push_back({32'h0000_0100, 32'hA5A5_0001});
    wait_acks(1, "single_ack");
    check("grant_latency", grant_cyc, full_rise_cyc + 1);
    check("push_to_wr_latency", rise_cyc, cap_cyc + 2);
    check("single_grants", grants, 1);
    check("single_exp_empty", exp_q.size(), 0);

    // Backpressure: FIFO plus one outstanding write, then zero-wait drain
    ack_block = 1; g0 = grants; a0 = acks;
    for (int i = 0; i < 6; i++) src_q.push_back({32'($urandom), 32'($urandom)});
    repeat (60) @(negedge clk);
    check("bp_grants", grants - g0, FIFO_DEPTH + 1);
    check("bp_wr_outstanding", {63'd0, sif.sram_wr}, 64'd1);
    check("bp_word_pending", src_q.size(), 1);
    acc_cyc.delete();
    ack_delay = 0;
    ack_block = 0;
    wait_acks(a0 + 6, "bp_acks");
    check("bp_grants_all", grants - g0, 6);
    for (int i = 0; i < 4; i++) check("zero_wait_gap", acc_cyc[i+1] - acc_cyc[i], 2);

    // Random traffic with random ack delays and stray acks while idle
    ack_rand = 1; ack_noise = 1; a0 = acks;
    for (int i = 0; i < 12; i++) begin
      src_q.push_back({32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    wait_acks(a0 + 12, "rand_acks");
    check("rand_exp_empty", exp_q.size(), 0);

    // End of image: two words, then the completion flag
    a0 = acks;
    src_q.push_back({32'h0000_0200, 32'h1234_5678});
    src_q.push_back({32'h0000_0204, 32'h9ABC_DEF0});
    wait_idle("eoi_words_taken");
    check("eoi_done_before", {63'd0, write_done}, 64'd0);
    flag_addr = DONE_FLAG_ADDR; flag_data = DONE_FLAG_WORD;
    exp_q.push_back({DONE_FLAG_ADDR, DONE_FLAG_WORD});
    img_req = 1;
    wait_done("eoi_done", dcyc);
    check("done_latency", dcyc, last_acc_cyc + 1);
    check("eoi_acks", acks - a0, 3);
    check("eoi_exp_empty", exp_q.size(), 0);
    g0 = grants;
    src_q.push_back({32'h0000_0300, 32'h0BAD_0BAD});
    repeat (20) @(negedge clk);
    check("done_no_grant", grants - g0, 0);
    check("done_sticky", {63'd0, write_done}, 64'd1);
    check("done_no_write", {63'd0, sif.sram_wr}, 64'd0);

    // Reset with one write outstanding and three queued
    n_rst = 1'b0; img_req = 0; src_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    ack_block = 1; ack_noise = 0; g0 = grants;
    for (int i = 0; i < 4; i++) src_q.push_back({32'($urandom), 32'($urandom)});
    wait_idle("rst_words_taken");
    check("rst_grants", grants - g0, 4);
    check("rst_wr_pending", {63'd0, sif.sram_wr}, 64'd1);
    @(posedge clk); #3;
    n_rst = 1'b0;
    #1;
    check_zero_outputs("async_reset");
    exp_q.delete(); src_q.delete();
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    ack_block = 0; a0 = acks;
    repeat (30) @(negedge clk);
    check("rst_no_writes", acks - a0, 0);
    check("rst_wr_idle", {63'd0, sif.sram_wr}, 64'd0);

    // img_done and out_full together in IDLE: flush wins, no grant
    g0 = grants; a0 = acks;
    flag_addr = DONE_FLAG_ADDR; flag_data = DONE_FLAG_WORD;
    exp_q.push_back({DONE_FLAG_ADDR, DONE_FLAG_WORD});
    src_q.push_back({32'h0000_0400, 32'hFEED_FACE});
    img_req = 1;
    wait_done("simul_done", dcyc);
    check("simul_no_grant", grants - g0, 0);
    check("simul_acks", acks - a0, 1);

`ifdef SRAM_WRITE_COUNT_EN
    n_rst = 1'b0; img_req = 0; src_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 n_rst = 1'b1;
    for (int i = 0; i < 10; i++) src_q.push_back({32'($urandom), 32'($urandom)});
    wait_idle("cnt_words_taken");
    exp_q.push_back({DONE_FLAG_ADDR, DONE_FLAG_WORD});
    img_req = 1;
    wait_done("cnt_done", dcyc);
    check("words_written", {48'd0, words_written}, 64'd11);
    check("fifo_overflow_err", {63'd0, fifo_overflow_err}, 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
